mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/sp_ram_256x8.sv | 45 ++++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: geometry, bus direction codes, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_responder_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;

    // Bus direction as seen on the rw input.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // FSM encoding: CLEAR zeroes the array once, SERVE is terminal until rst.
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

endpackage

// File: rtl/sp_ram_256x8.sv
// 256x8 storage array; port A and port B writes, one registered read port.
// Latency: write visible to a read issued the next cycle; read data one cycle after rd_en.
// Backpressure: none, accepts one read and the writes every cycle.
module sp_ram_256x8
    import mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_dat,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] rd_dat_q;
    logic [DATA_W-1:0] rd_dat_d;

    // Array update; the caller has already resolved same-address collisions,
    // port A is written last so it would still win if both ever matched.
    always_ff @(posedge clk) begin
        if (b_we) mem[b_addr] <= b_dat;
        if (a_we) mem[a_addr] <= a_dat;
    end

    // Read data captures the pre-write contents and holds when no read occurs.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) rd_dat_d = mem[rd_addr];
    end

    // Read register: only this register is reset, never the array itself.
    always_ff @(posedge clk) begin
        if (rst) rd_dat_q <= '0;
        else     rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/mem_responder.sv
// CPU-side memory responder: clears 256 words after reset, then serves bus reads/writes.
// Latency: read data and rvalid one cycle after the accepted read; writes take effect at the edge.
// Backpressure: none; accesses during CLEAR are dropped and flagged on err.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              ready,
    output logic              err
);

    localparam logic [0:0] RST_STATE = CLEAR_ON_RST ? ST_CLEAR : ST_SERVE;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic              err_q,   err_d;
    logic              rvalid_q, rvalid_d;

    logic              in_clear, in_serve;
    logic              clr_wr, bus_wr, bus_rd;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_dat;

    assign in_clear = (state_q == ST_CLEAR);
    assign in_serve = (state_q == ST_SERVE);

    // Access qualification; a cycle with rst high drops every bus access.
    always_comb begin
        clr_wr = in_clear && !rst;
        bus_wr = en && (rw == RW_WRITE) && in_serve && !rst;
        bus_rd = en && (rw == RW_READ)  && in_serve && !rst;
    end

    // Write-port priority: prog owns port A; port B carries the clear or bus
    // write and is suppressed when prog targets the same word.
    always_comb begin
        b_addr = addr;
        b_dat  = wdata;
        if (in_clear) begin
            b_addr = cnt_q;
            b_dat  = '0;
        end
        b_we = (clr_wr || bus_wr) && !(prog_we && (prog_addr == b_addr));
    end

    // Next-state: clear pass advances once per cycle and exits on word 255.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rvalid_d = bus_rd;
        if (in_clear) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(MEM_DEPTH - 1)) state_d = ST_SERVE;
            if (en) err_d = 1'b1;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

    sp_ram_256x8 u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_we    (prog_we),
        .a_addr  (prog_addr),
        .a_dat   (prog_data),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_dat   (b_dat),
        .rd_en   (bus_rd),
        .rd_addr (addr),
        .rd_dat  (rdata)
    );

    assign rvalid = rvalid_q;
    assign ready  = in_serve;
    assign err    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset/clear timing, vector table in SERVE, CLEAR corner cases.
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: n/a.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, rw, prog_we;
    logic [7:0] addr, wdata, prog_addr, prog_data;
    logic [7:0] rdata;
    logic       rvalid, ready, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.CLEAR_ON_RST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .ready     (ready),
        .err       (err)
    );

    typedef struct {
        logic       en;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       prog_we;
        logic [7:0] prog_addr;
        logic [7:0] prog_data;
        logic       exp_rvalid;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        en = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00;
        prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic r, input logic [7:0] a, input logic [7:0] d);
        en = 1'b1; rw = r; addr = a; wdata = d;
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
    endtask

    // Two reset edges, then release; leaves the bench 1 ns after the last reset edge.
    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        //                 en  rw    addr   wdata  pwe  paddr  pdata  rvld  rdata
        vecs[0]  = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 8'h10, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h5A};
        vecs[4]  = '{1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h5A};
        vecs[5]  = '{1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 8'h00, 8'h00, 1'b0, 8'h5A};
        vecs[6]  = '{1'b1, 1'b0, 8'h20, 8'h11, 1'b1, 8'h20, 8'hC3, 1'b0, 8'h5A};
        vecs[7]  = '{1'b1, 1'b1, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC3};
        vecs[8]  = '{1'b1, 1'b0, 8'h30, 8'h07, 1'b0, 8'h00, 8'h00, 1'b0, 8'hC3};
        vecs[9]  = '{1'b1, 1'b1, 8'h30, 8'h00, 1'b1, 8'h30, 8'h99, 1'b1, 8'h07};
        vecs[10] = '{1'b1, 1'b1, 8'h30, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h99};
        vecs[11] = '{1'b1, 1'b0, 8'h51, 8'hBB, 1'b1, 8'h50, 8'hAA, 1'b0, 8'h99};
        vecs[12] = '{1'b1, 1'b1, 8'h50, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hAA};
        vecs[13] = '{1'b1, 1'b1, 8'h51, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hBB};
        vecs[14] = '{1'b1, 1'b0, 8'hFF, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b0, 8'hBB};
        vecs[15] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h3C};
        vecs[16] = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};

        // Reset state.
        do_reset();
        check("rst_ready",  {7'd0, ready},  8'h00);
        check("rst_rvalid", {7'd0, rvalid}, 8'h00);
        check("rst_rdata",  rdata,          8'h00);
        check("rst_err",    {7'd0, err},    8'h00);

        // Idle clear pass: ready low through edge 255, high on edge 256.
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 1)   check("clr_ready_e1",   {7'd0, ready}, 8'h00);
            if (i == 255) check("clr_ready_e255", {7'd0, ready}, 8'h00);
            if (i == 256) check("clr_ready_e256", {7'd0, ready}, 8'h01);
        end

        // Vector table in SERVE.
        for (int v = 0; v < 17; v++) begin
            en = vecs[v].en; rw = vecs[v].rw; addr = vecs[v].addr; wdata = vecs[v].wdata;
            prog_we = vecs[v].prog_we; prog_addr = vecs[v].prog_addr; prog_data = vecs[v].prog_data;
            tick();
            check($sformatf("vec%0d_rvalid", v), {7'd0, rvalid}, {7'd0, vecs[v].exp_rvalid});
            check($sformatf("vec%0d_rdata", v),  rdata,          vecs[v].exp_rdata);
            check($sformatf("vec%0d_err", v),    {7'd0, err},    8'h00);
        end
        idle();
        tick();
        check("rvalid_drop", {7'd0, rvalid}, 8'h00);

        // Reset mid-SERVE with a read in the same cycle: read is dropped.
        bus(1'b1, 8'h30, 8'h00);
        rst = 1'b1;
        tick();
        check("rst_serve_rvalid", {7'd0, rvalid}, 8'h00);
        check("rst_serve_rdata",  rdata,          8'h00);
        check("rst_serve_ready",  {7'd0, ready},  8'h00);
        idle();
        tick();
        rst = 1'b0;

        // Clear pass with an access at counter 10, reset at counter 100.
        for (int i = 1; i <= 100; i++) begin
            idle();
            if (i == 11) bus(1'b0, 8'h03, 8'h77);
            tick();
            if (i == 11) begin
                check("clr_acc_err",    {7'd0, err},    8'h01);
                check("clr_acc_rvalid", {7'd0, rvalid}, 8'h00);
            end
            if (i == 60) check("clr_err_sticky", {7'd0, err}, 8'h01);
        end
        idle();
        rst = 1'b1;
        tick();
        check("midclr_rst_ready", {7'd0, ready}, 8'h00);
        check("midclr_rst_err",   {7'd0, err},   8'h00);
        rst = 1'b0;

        // Restarted clear: bus write at counter 10 ignored, prog write in CLEAR kept.
        for (int i = 1; i <= 256; i++) begin
            idle();
            if (i == 11) bus(1'b0, 8'h03, 8'h77);
            if (i == 21) prog(8'h05, 8'h66);
            tick();
            if (i == 255) check("reclr_ready_e255", {7'd0, ready}, 8'h00);
            if (i == 256) check("reclr_ready_e256", {7'd0, ready}, 8'h01);
        end
        check("reclr_err_held", {7'd0, err}, 8'h01);

        bus(1'b1, 8'h03, 8'h00);
        tick();
        check("ignored_wr_rvalid", {7'd0, rvalid}, 8'h01);
        check("ignored_wr_rdata",  rdata,          8'h00);
        bus(1'b1, 8'h05, 8'h00);
        tick();
        check("prog_in_clear", rdata, 8'h66);
        bus(1'b1, 8'h10, 8'h00);
        tick();
        check("recleared_word", rdata, 8'h00);
        idle();
        tick();
        check("final_err", {7'd0, err}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
